network_to_axil_converter: RTL and testbench
============================================

# network_to_axil_converter

Downstream consumer of the control-path splitter's request branch. It accepts MSG_READ/MSG_WRITE request messages from the network bridge, performs the corresponding single AXI4-Lite master transaction, and returns a MSG_RDATA, MSG_BRESP or MSG_BUSY reply stream towards the network bridge. It handles one transaction at a time and applies a per-transaction timeout.

## Interface
- AXIS_DATA_WIDTH, 64: request/reply tdata width; fixed at 64 for this message format.
- AXIS_KEEP_WIDTH, 8: tkeep width.
- AXIS_FROM_NB_TDEST_WIDTH, 8: tid/tdest width.
- AXIS_FROM_NB_TUSER_WIDTH, 1: tuser width.
- MSG_TYPE_WIDTH, 8: message type field, tdata[7:0]. Encodings: MSG_READ=0, MSG_WRITE=1, MSG_BRESP=2, MSG_RDATA=3, MSG_BUSY=4.
- TIMEOUT_CYCLES, 1024: maximum cycles from issuing AR/AW until R/B before a MSG_BUSY reply; must be ≥2.
- i_clk, input, 1: single clock.
- i_ap_rst_n, input, 1: asynchronous, active-low reset.
- from_splitter_{tvalid,tready,tdata,tkeep,tid,tdest,tuser,tlast}, in/out(tready)/in, widths per parameters: request AXIS slave.
- to_network_bridge_{tvalid,tready,tdata,tkeep,tid,tdest,tuser,tlast}, out/in(tready)/out: reply AXIS master.
- m_axil_{awvalid,awready,awaddr[31:0],awprot[2:0]}, {wvalid,wready,wdata[31:0],wstrb[3:0]}, {bvalid,bready,bresp[1:0]}, {arvalid,arready,araddr[31:0],arprot[2:0]}, {rvalid,rready,rdata[31:0],rresp[1:0]}: AXI4-Lite master; awprot/arprot tied to 3'b000.

## Operation
- Read request: 1 beat, tlast=1, tdata[63:32] = address.
- Write request: 2 beats. Beat0 carries type and addr[63:32], tlast=0. Beat1 carries data[31:0], strb[35:32], tlast=1.
- Replies are always 1 beat, tkeep=all ones, tlast=1, tuser=0, reply tdest = request tid, reply tid = request tdest.
  - MSG_RDATA: [9:8]=rresp, [63:32]=rdata.
  - MSG_BRESP: [9:8]=bresp.
  - MSG_BUSY: [63:32]=address of the timed-out request.
  - All other bits are 0.
- FSM states: IDLE, WR_DATA, RD_ADDR, RD_RESP, WR_ADDR, WR_RESP, REPLY, DRAIN, DISCARD.
- IDLE:
  - READ with tlast=1 → RD_ADDR.
  - READ with tlast=0 → DISCARD.
  - WRITE with tlast=0 → WR_DATA.
  - WRITE with tlast=1 → IDLE, dropped, no reply.
  - Any other type → DISCARD if tlast=0, else dropped silently.
- WR_DATA:
  - Next beat with tlast=1 → WR_ADDR.
  - Beat with tlast=0 → DISCARD, no reply.
- RD_ADDR: arvalid=1 until arready; then RD_RESP with rready=1.
- WR_ADDR: awvalid and wvalid asserted together; each drops independently on its own handshake; after both → WR_RESP with bready=1.
- RD_RESP/WR_RESP: on rvalid/bvalid, latch the reply → REPLY.
- REPLY: to_network_bridge_tvalid=1 until tready → IDLE.
- Timeout: counter clears on entry to RD_ADDR/WR_ADDR and increments each cycle in RD_ADDR/RD_RESP/WR_ADDR/WR_RESP.
  - Reaching TIMEOUT_CYCLES-1 without the R/B handshake → build MSG_BUSY, go to REPLY, and set a pending-drain flag.
  - After that reply, go to DRAIN instead of IDLE.
- DRAIN:
  - Keep any still-unhandshaken arvalid/awvalid/wvalid asserted until accepted.
  - Hold rready/bready=1 until the outstanding R/B handshake, discard that response, then → IDLE.
  - A timeout is never raised twice per transaction.
- DISCARD: tready=1, drop beats until tlast, then → IDLE.

## Timing
- Reset values:
  - All *valid outputs, rready, bready and from_splitter_tready are 0; tdata/addr/data outputs are 0.
  - State is IDLE; counter and drain flag are 0.
  - Reset mid-transaction abandons it immediately, with no reply.
- from_splitter_tready is registered: 1 only in IDLE, WR_DATA and DISCARD.
  - It is 0 in the cycle after a terminating beat is accepted, so requests never overlap.
- arvalid/awvalid/wvalid rise the cycle after the final request beat is accepted.
- Reply tvalid rises the cycle after the R/B handshake (or the timeout cycle).
- Read latency with zero-wait slave and sink: accept at N, arvalid N+1, R handshake N+2, reply tvalid N+3, next request accepted N+4 at earliest.
- All AXI and AXIS outputs are stable while valid is high and ready is low.

## Test plan
- Read 0x0000_0010, tid=3/tdest=7; slave returns rdata=0xDEADBEEF, rresp=0 → one reply beat: type 3, [63:32]=0xDEADBEEF, tdest=3, tid=7, tlast=1.
- Write addr 0x20, data 0x12345678, strb 0xF; slave returns awready one cycle before wready, bresp=2'b10 → AW/W each drop after their own handshake; reply type 2, [9:8]=2'b10.
- Read with arready held low for TIMEOUT_CYCLES (set to 16) → MSG_BUSY at cycle 16 with address echoed. A late R is then consumed with no second reply, and the next request is serviced normally.
- Malformed input: WRITE with tlast on beat0, a 3-beat READ, and type 5 → no AXI activity and no replies; a following valid read succeeds.
- Reply backpressure: to_network_bridge_tready low for 10 cycles → reply beat held stable and from_splitter_tready stays 0 throughout.
- Reset asserted during WR_RESP → all outputs return to reset values asynchronously; after release a new read completes correctly.

Source files
------------

// File: rtl/network_to_axil_converter.sv
// Bridges single-transaction READ/WRITE request messages to an AXI4-Lite master and
// returns one RDATA/BRESP/BUSY reply beat, with a per-transaction response timeout.
`timescale 1ns/1ps
module network_to_axil_converter #(
    parameter int AXIS_DATA_WIDTH          = 64,
    parameter int AXIS_KEEP_WIDTH          = 8,
    parameter int AXIS_FROM_NB_TDEST_WIDTH = 8,
    parameter int AXIS_FROM_NB_TUSER_WIDTH = 1,
    parameter int MSG_TYPE_WIDTH           = 8,
    parameter int TIMEOUT_CYCLES           = 1024
) (
    input  logic                                i_clk,
    input  logic                                i_ap_rst_n,
    input  logic                                from_splitter_tvalid,
    output logic                                from_splitter_tready,
    input  logic [AXIS_DATA_WIDTH-1:0]          from_splitter_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0]          from_splitter_tkeep,
    input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_splitter_tid,
    input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] from_splitter_tdest,
    input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] from_splitter_tuser,
    input  logic                                from_splitter_tlast,
    output logic                                to_network_bridge_tvalid,
    input  logic                                to_network_bridge_tready,
    output logic [AXIS_DATA_WIDTH-1:0]          to_network_bridge_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0]          to_network_bridge_tkeep,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_network_bridge_tid,
    output logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] to_network_bridge_tdest,
    output logic [AXIS_FROM_NB_TUSER_WIDTH-1:0] to_network_bridge_tuser,
    output logic                                to_network_bridge_tlast,
    output logic                                m_axil_awvalid,
    input  logic                                m_axil_awready,
    output logic [31:0]                         m_axil_awaddr,
    output logic [2:0]                          m_axil_awprot,
    output logic                                m_axil_wvalid,
    input  logic                                m_axil_wready,
    output logic [31:0]                         m_axil_wdata,
    output logic [3:0]                          m_axil_wstrb,
    input  logic                                m_axil_bvalid,
    output logic                                m_axil_bready,
    input  logic [1:0]                          m_axil_bresp,
    output logic                                m_axil_arvalid,
    input  logic                                m_axil_arready,
    output logic [31:0]                         m_axil_araddr,
    output logic [2:0]                          m_axil_arprot,
    input  logic                                m_axil_rvalid,
    output logic                                m_axil_rready,
    input  logic [31:0]                         m_axil_rdata,
    input  logic [1:0]                          m_axil_rresp
);
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_READ  = 8'd0;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_WRITE = 8'd1;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_BRESP = 8'd2;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_RDATA = 8'd3;
    localparam logic [MSG_TYPE_WIDTH-1:0] MSG_BUSY  = 8'd4;
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, WR_DATA, RD_ADDR, RD_RESP, WR_ADDR, WR_RESP, REPLY, DRAIN, DISCARD
    } state_t;

    state_t state_r, next_s;
    logic [CNT_W-1:0] cnt_r;
    logic drain_r, s_tready_r, reply_valid_r;
    logic arvalid_r, awvalid_r, wvalid_r, rready_r, bready_r;
    logic [31:0] addr_r, wdata_r;
    logic [3:0] wstrb_r;
    logic [AXIS_FROM_NB_TDEST_WIDTH-1:0] req_tid_r, req_tdest_r;
    logic [63:0] reply_data_r;

    logic in_hs_s, ar_hs_s, aw_hs_s, w_hs_s, r_hs_s, b_hs_s, rep_hs_s;
    logic busy_state_s, timeout_s, wr_addr_done_s, drain_done_s;
    logic enter_rd_s, enter_wr_s, enter_reply_s;
    logic [MSG_TYPE_WIDTH-1:0] req_type_s;
    logic unused_s;

    assign in_hs_s   = from_splitter_tvalid && s_tready_r;
    assign ar_hs_s   = arvalid_r && m_axil_arready;
    assign aw_hs_s   = awvalid_r && m_axil_awready;
    assign w_hs_s    = wvalid_r && m_axil_wready;
    assign r_hs_s    = rready_r && m_axil_rvalid;
    assign b_hs_s    = bready_r && m_axil_bvalid;
    assign rep_hs_s  = reply_valid_r && to_network_bridge_tready;
    assign req_type_s = from_splitter_tdata[MSG_TYPE_WIDTH-1:0];
    assign unused_s  = ^{from_splitter_tkeep, from_splitter_tuser};

    assign busy_state_s = (state_r == RD_ADDR) || (state_r == RD_RESP) ||
                          (state_r == WR_ADDR) || (state_r == WR_RESP);
    assign timeout_s    = busy_state_s && (cnt_r == CNT_MAX) && !(r_hs_s || b_hs_s);
    // AW and W complete independently; bready rises once the later of the two is accepted.
    assign wr_addr_done_s = (aw_hs_s || w_hs_s) && (!awvalid_r || aw_hs_s) && (!wvalid_r || w_hs_s);
    assign drain_done_s   = r_hs_s || b_hs_s ||
                            !(arvalid_r || awvalid_r || wvalid_r || rready_r || bready_r);
    assign enter_rd_s     = (state_r == IDLE) && (next_s == RD_ADDR);
    assign enter_wr_s     = (state_r == WR_DATA) && (next_s == WR_ADDR);
    assign enter_reply_s  = (state_r != REPLY) && (next_s == REPLY);

    // Next-state decode
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (!in_hs_s) begin
                    next_s = IDLE;
                end else if (req_type_s == MSG_READ) begin
                    next_s = from_splitter_tlast ? RD_ADDR : DISCARD;
                end else if (req_type_s == MSG_WRITE) begin
                    next_s = from_splitter_tlast ? IDLE : WR_DATA;
                end else begin
                    next_s = from_splitter_tlast ? IDLE : DISCARD;
                end
            end
            WR_DATA: begin
                if (in_hs_s) next_s = from_splitter_tlast ? WR_ADDR : DISCARD;
                else         next_s = WR_DATA;
            end
            RD_ADDR: begin
                if (timeout_s)    next_s = REPLY;
                else if (ar_hs_s) next_s = RD_RESP;
                else              next_s = RD_ADDR;
            end
            RD_RESP: begin
                if (r_hs_s || timeout_s) next_s = REPLY;
                else                     next_s = RD_RESP;
            end
            WR_ADDR: begin
                if (timeout_s)           next_s = REPLY;
                else if (wr_addr_done_s) next_s = WR_RESP;
                else                     next_s = WR_ADDR;
            end
            WR_RESP: begin
                if (b_hs_s || timeout_s) next_s = REPLY;
                else                     next_s = WR_RESP;
            end
            REPLY: begin
                if (rep_hs_s) next_s = drain_r ? DRAIN : IDLE;
                else          next_s = REPLY;
            end
            DRAIN: begin
                if (drain_done_s) next_s = IDLE;
                else              next_s = DRAIN;
            end
            DISCARD: begin
                if (in_hs_s && from_splitter_tlast) next_s = IDLE;
                else                                next_s = DISCARD;
            end
            default: next_s = IDLE;
        endcase
    end

    // State, handshake flags, timeout counter and drain tracking
    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            drain_r       <= 1'b0;
            s_tready_r    <= 1'b0;
            reply_valid_r <= 1'b0;
            arvalid_r     <= 1'b0;
            awvalid_r     <= 1'b0;
            wvalid_r      <= 1'b0;
            rready_r      <= 1'b0;
            bready_r      <= 1'b0;
        end else begin
            state_r       <= next_s;
            s_tready_r    <= ((next_s == IDLE) || (next_s == WR_DATA) || (next_s == DISCARD)) &&
                             !(in_hs_s && from_splitter_tlast);
            reply_valid_r <= (next_s == REPLY);
            if (enter_rd_s)   arvalid_r <= 1'b1;
            else if (ar_hs_s) arvalid_r <= 1'b0;
            if (enter_wr_s)   awvalid_r <= 1'b1;
            else if (aw_hs_s) awvalid_r <= 1'b0;
            if (enter_wr_s)   wvalid_r <= 1'b1;
            else if (w_hs_s)  wvalid_r <= 1'b0;
            if (ar_hs_s)      rready_r <= 1'b1;
            else if (r_hs_s)  rready_r <= 1'b0;
            if (wr_addr_done_s) bready_r <= 1'b1;
            else if (b_hs_s)    bready_r <= 1'b0;
            if (enter_rd_s || enter_wr_s) cnt_r <= '0;
            else if (busy_state_s)        cnt_r <= cnt_r + 1'b1;
            if (timeout_s)                                 drain_r <= 1'b1;
            else if ((state_r == DRAIN) && (next_s == IDLE)) drain_r <= 1'b0;
        end
    end

    // Request capture and reply payload
    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            wstrb_r      <= 4'd0;
            req_tid_r    <= '0;
            req_tdest_r  <= '0;
            reply_data_r <= 64'd0;
        end else begin
            if ((state_r == IDLE) && in_hs_s) begin
                addr_r      <= from_splitter_tdata[63:32];
                req_tid_r   <= from_splitter_tid;
                req_tdest_r <= from_splitter_tdest;
            end
            if ((state_r == WR_DATA) && in_hs_s) begin
                wdata_r <= from_splitter_tdata[31:0];
                wstrb_r <= from_splitter_tdata[35:32];
            end
            if (enter_reply_s) begin
                if (r_hs_s)      reply_data_r <= {m_axil_rdata, 22'd0, m_axil_rresp, MSG_RDATA};
                else if (b_hs_s) reply_data_r <= {32'd0, 22'd0, m_axil_bresp, MSG_BRESP};
                else             reply_data_r <= {addr_r, 24'd0, MSG_BUSY};
            end
        end
    end

    assign from_splitter_tready     = s_tready_r;
    assign to_network_bridge_tvalid = reply_valid_r;
    assign to_network_bridge_tdata  = reply_data_r;
    assign to_network_bridge_tkeep  = {AXIS_KEEP_WIDTH{1'b1}};
    assign to_network_bridge_tid    = req_tdest_r;
    assign to_network_bridge_tdest  = req_tid_r;
    assign to_network_bridge_tuser  = {AXIS_FROM_NB_TUSER_WIDTH{1'b0}};
    assign to_network_bridge_tlast  = 1'b1;
    assign m_axil_awvalid = awvalid_r;
    assign m_axil_awaddr  = addr_r;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_wvalid  = wvalid_r;
    assign m_axil_wdata   = wdata_r;
    assign m_axil_wstrb   = wstrb_r;
    assign m_axil_bready  = bready_r;
    assign m_axil_arvalid = arvalid_r;
    assign m_axil_araddr  = addr_r;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_rready  = rready_r;
endmodule

// File: tb/tb_network_to_axil_converter.sv
// Scoreboard bench: reply and AXI expectations are queued when requests are driven and
// compared when the converter produces them, with a small AXI4-Lite slave model.
`timescale 1ns/1ps
module tb_network_to_axil_converter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        fs_tvalid = 1'b0, fs_tready, fs_tlast = 1'b0;
    logic [63:0] fs_tdata = 64'd0;
    logic [7:0]  fs_tkeep = 8'hFF, fs_tid = 8'd0, fs_tdest = 8'd0;
    logic [0:0]  fs_tuser = 1'b0;
    logic        nb_tvalid, nb_tready = 1'b1, nb_tlast;
    logic [63:0] nb_tdata;
    logic [7:0]  nb_tkeep, nb_tid, nb_tdest;
    logic [0:0]  nb_tuser;
    logic        awvalid, awready = 1'b1, wvalid, wready = 1'b1, bvalid, bready;
    logic        arvalid, arready = 1'b1, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    network_to_axil_converter #(.TIMEOUT_CYCLES(16)) dut (
        .i_clk(clk), .i_ap_rst_n(rst_n),
        .from_splitter_tvalid(fs_tvalid), .from_splitter_tready(fs_tready),
        .from_splitter_tdata(fs_tdata), .from_splitter_tkeep(fs_tkeep),
        .from_splitter_tid(fs_tid), .from_splitter_tdest(fs_tdest),
        .from_splitter_tuser(fs_tuser), .from_splitter_tlast(fs_tlast),
        .to_network_bridge_tvalid(nb_tvalid), .to_network_bridge_tready(nb_tready),
        .to_network_bridge_tdata(nb_tdata), .to_network_bridge_tkeep(nb_tkeep),
        .to_network_bridge_tid(nb_tid), .to_network_bridge_tdest(nb_tdest),
        .to_network_bridge_tuser(nb_tuser), .to_network_bridge_tlast(nb_tlast),
        .m_axil_awvalid(awvalid), .m_axil_awready(awready), .m_axil_awaddr(awaddr),
        .m_axil_awprot(awprot), .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_bvalid(bvalid),
        .m_axil_bready(bready), .m_axil_bresp(bresp), .m_axil_arvalid(arvalid),
        .m_axil_arready(arready), .m_axil_araddr(araddr), .m_axil_arprot(arprot),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready), .m_axil_rdata(rdata),
        .m_axil_rresp(rresp)
    );

    int checks = 0;
    int errors = 0;
    logic [79:0] exp_q[$];   // {tdata, tdest, tid}
    logic [31:0] ar_q[$];
    logic [31:0] aw_q[$];
    logic [35:0] w_q[$];     // {strb, data}
    int ar_cnt = 0, aw_cnt = 0;
    logic b_hold = 1'b0, aw_seen = 1'b0, w_seen = 1'b0;
    logic [31:0] slv_rdata = 32'd0;
    logic [1:0]  slv_rresp = 2'd0, slv_bresp = 2'd0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic        s_ar, s_aw, s_w, s_r, s_b, s_rep;
    logic [31:0] s_araddr, s_awaddr, s_wdata;
    logic [3:0]  s_wstrb;
    logic [63:0] s_rdata;
    logic [15:0] s_route;
    logic [9:0]  s_misc;
    logic [79:0] s_exp;

    // AXI4-Lite slave model and reply monitor: sample at the edge, respond #1 later
    initial begin
        rvalid = 1'b0; bvalid = 1'b0; rdata = 32'd0; rresp = 2'd0; bresp = 2'd0;
        forever begin
            @(posedge clk);
            s_ar = arvalid && arready; s_aw = awvalid && awready; s_w = wvalid && wready;
            s_r = rvalid && rready;    s_b = bvalid && bready;    s_rep = nb_tvalid && nb_tready;
            s_araddr = araddr; s_awaddr = awaddr; s_wdata = wdata; s_wstrb = wstrb;
            s_rdata = nb_tdata; s_route = {nb_tdest, nb_tid}; s_misc = {nb_tlast, nb_tkeep, nb_tuser};
            #1;
            if (s_r) rvalid = 1'b0;
            if (s_b) bvalid = 1'b0;
            if (s_ar) begin
                ar_cnt++;
                if (ar_q.size() == 0) check("ar_unexpected", 64'd1, 64'd0);
                else check("araddr", 64'(s_araddr), 64'(ar_q.pop_front()));
                rvalid = 1'b1; rdata = slv_rdata; rresp = slv_rresp;
            end
            if (s_aw) begin
                aw_cnt++; aw_seen = 1'b1;
                if (aw_q.size() == 0) check("aw_unexpected", 64'd1, 64'd0);
                else check("awaddr", 64'(s_awaddr), 64'(aw_q.pop_front()));
            end
            if (s_w) begin
                w_seen = 1'b1;
                if (w_q.size() == 0) check("w_unexpected", 64'd1, 64'd0);
                else check("wdata_strb", 64'({s_wstrb, s_wdata}), 64'(w_q.pop_front()));
            end
            if (aw_seen && w_seen) begin
                aw_seen = 1'b0; w_seen = 1'b0;
                if (!b_hold) begin bvalid = 1'b1; bresp = slv_bresp; end
            end
            if (s_rep) begin
                if (exp_q.size() == 0) check("reply_unexpected", s_rdata, 64'd0);
                else begin
                    s_exp = exp_q.pop_front();
                    check("reply_data", s_rdata, s_exp[79:16]);
                    check("reply_route", 64'(s_route), 64'(s_exp[15:0]));
                    check("reply_misc", 64'(s_misc), 64'({1'b1, 8'hFF, 1'b0}));
                end
            end
        end
    end

    task automatic send_beat(input logic [63:0] d, input logic [7:0] id, input logic [7:0] dst,
                             input logic last);
        int n = 0;
        fs_tvalid = 1'b1; fs_tdata = d; fs_tid = id; fs_tdest = dst; fs_tlast = last;
        do begin
            @(posedge clk);
            n++;
        end while (!fs_tready && n < 300);
        if (!fs_tready) check("tready_wait", 64'd0, 64'd1);
        #1 fs_tvalid = 1'b0;
    endtask

    task automatic wait_replies();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("reply_wait", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int ar_before;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", 64'({arvalid, awvalid, wvalid, rready, bready, fs_tready, nb_tvalid}), 64'd0);
        check("rst_tdata", nb_tdata, 64'd0);
        check("rst_addr", 64'({awaddr, araddr}), 64'd0);
        check("rst_wdata", 64'({wstrb, wdata}), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_tready", 64'(fs_tready), 64'd1);

        // Zero-wait read with latency check
        slv_rdata = 32'hDEADBEEF; slv_rresp = 2'd0;
        ar_q.push_back(32'h10);
        exp_q.push_back({32'hDEADBEEF, 22'd0, 2'd0, 8'd3, 8'd3, 8'd7});
        send_beat({32'h10, 24'd0, 8'd0}, 8'd3, 8'd7, 1'b1);
        check("tready_after_last", 64'(fs_tready), 64'd0);
        check("arvalid_n1", 64'(arvalid), 64'd1);
        @(posedge clk); #1;
        check("rd_lat_n2", 64'(nb_tvalid), 64'd0);
        @(posedge clk); #1;
        check("rd_lat_n3", 64'(nb_tvalid), 64'd1);
        wait_replies();

        // Write: AW accepted one cycle before W, bresp SLVERR
        awready = 1'b1; wready = 1'b0; slv_bresp = 2'b10;
        aw_q.push_back(32'h20); w_q.push_back({4'hF, 32'h12345678});
        exp_q.push_back({32'd0, 22'd0, 2'b10, 8'd2, 8'd0, 8'd0});
        n = aw_cnt;
        send_beat({32'h20, 24'd0, 8'd1}, 8'd0, 8'd0, 1'b0);
        send_beat({28'd0, 4'hF, 32'h12345678}, 8'd0, 8'd0, 1'b1);
        for (int i = 0; i < 50 && aw_cnt == n; i++) begin @(posedge clk); #2; end
        check("aw_drop_w_hold", 64'({awvalid, wvalid}), 64'({1'b0, 1'b1}));
        wready = 1'b1;
        wait_replies();

        // Timeout: arready held low, BUSY after 16 cycles, late R drained silently
        arready = 1'b0; slv_rdata = 32'h55AA55AA;
        ar_q.push_back(32'h100);
        exp_q.push_back({32'h100, 24'd0, 8'd4, 8'd1, 8'd2});
        send_beat({32'h100, 24'd0, 8'd0}, 8'd1, 8'd2, 1'b1);
        repeat (15) @(posedge clk);
        #1 check("busy_early", 64'(nb_tvalid), 64'd0);
        @(posedge clk); #1;
        check("busy_at_16", 64'(nb_tvalid), 64'd1);
        wait_replies();
        check("drain_tready", 64'(fs_tready), 64'd0);
        arready = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("drain_done_tready", 64'(fs_tready), 64'd1);
        slv_rdata = 32'hCAFEF00D; slv_rresp = 2'b01;
        ar_q.push_back(32'h200);
        exp_q.push_back({32'hCAFEF00D, 22'd0, 2'b01, 8'd3, 8'd9, 8'd8});
        send_beat({32'h200, 24'd0, 8'd0}, 8'd9, 8'd8, 1'b1);
        wait_replies();

        // Malformed requests: no AXI activity, no replies
        ar_before = ar_cnt; n = aw_cnt;
        send_beat({32'h50, 24'd0, 8'd1}, 8'd0, 8'd0, 1'b1);
        send_beat({32'h60, 24'd0, 8'd0}, 8'd0, 8'd0, 1'b0);
        send_beat(64'h1111_2222_3333_4444, 8'd0, 8'd0, 1'b0);
        send_beat(64'h5555_6666_7777_8888, 8'd0, 8'd0, 1'b1);
        send_beat({32'h70, 24'd0, 8'd5}, 8'd0, 8'd0, 1'b1);
        send_beat({32'h72, 24'd0, 8'd5}, 8'd0, 8'd0, 1'b0);
        send_beat(64'h9, 8'd0, 8'd0, 1'b1);
        repeat (5) @(posedge clk);
        #1 check("malformed_no_axi", 64'({ar_cnt - ar_before, aw_cnt - n}), 64'd0);
        slv_rdata = 32'h01020304; slv_rresp = 2'd0;
        ar_q.push_back(32'h80);
        exp_q.push_back({32'h01020304, 22'd0, 2'd0, 8'd3, 8'd4, 8'd6});
        send_beat({32'h80, 24'd0, 8'd0}, 8'd4, 8'd6, 1'b1);
        wait_replies();

        // Reply backpressure for 10 cycles
        nb_tready = 1'b0; slv_rdata = 32'h0BADF00D; slv_rresp = 2'b01;
        ar_q.push_back(32'h30);
        exp_q.push_back({32'h0BADF00D, 22'd0, 2'b01, 8'd3, 8'd5, 8'd4});
        send_beat({32'h30, 24'd0, 8'd0}, 8'd5, 8'd4, 1'b1);
        n = 0;
        while (!nb_tvalid && n < 50) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 10; i++) begin
            check("bp_hold", 64'({nb_tvalid, fs_tready, nb_tdest, nb_tid}), 64'({1'b1, 1'b0, 8'd5, 8'd4}));
            check("bp_data", nb_tdata, {32'h0BADF00D, 22'd0, 2'b01, 8'd3});
            @(posedge clk); #1;
        end
        nb_tready = 1'b1;
        wait_replies();

        // Reset while waiting for B
        b_hold = 1'b1;
        aw_q.push_back(32'h40); w_q.push_back({4'h3, 32'hA5A5A5A5});
        send_beat({32'h40, 24'd0, 8'd1}, 8'd0, 8'd0, 1'b0);
        send_beat({28'd0, 4'h3, 32'hA5A5A5A5}, 8'd0, 8'd0, 1'b1);
        n = 0;
        while (!bready && n < 50) begin @(posedge clk); #1; n++; end
        check("wr_resp_reached", 64'(bready), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ctl", 64'({arvalid, awvalid, wvalid, rready, bready, fs_tready, nb_tvalid}), 64'd0);
        check("arst_data", 64'({awaddr, wdata}), 64'd0);
        check("arst_tdata", nb_tdata, 64'd0);
        @(negedge clk);
        b_hold = 1'b0; aw_seen = 1'b0; w_seen = 1'b0;
        rst_n = 1'b1;
        slv_rdata = 32'h600DCAFE; slv_rresp = 2'd0;
        ar_q.push_back(32'h90);
        exp_q.push_back({32'h600DCAFE, 22'd0, 2'd0, 8'd3, 8'd2, 8'd1});
        send_beat({32'h90, 24'd0, 8'd0}, 8'd2, 8'd1, 1'b1);
        wait_replies();

        check("axi_queues_empty", 64'(ar_q.size() + aw_q.size() + w_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
